// File: rtl/waveform_playback_buffer.sv
`default_nettype none
// ============================================================================
// Module      : waveform_playback_buffer
// Description : Captures one waveform from an AXI4-Stream input into block RAM
//               and replays it on an AXI4-Stream output, either a programmed
//               number of times or continuously until a graceful stop.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module waveform_playback_buffer #(
  parameter int DATA_WIDTH        = 32,
  parameter int ADDR_WIDTH        = 10,
  parameter int WRITE_BEFORE_READ = 1
) (
  input  logic                    clk_in1,
  input  logic                    aresetn,
  input  logic [127:0]            waveform_parameters,
  input  logic                    init_wf_write,
  input  logic                    init_wf_read,
  input  logic                    stop_wf_read,
  output logic                    wf_write_ready,
  output logic                    wf_read_ready,
  output logic                    wf_busy,
  output logic                    wf_len_error,
  input  logic [DATA_WIDTH-1:0]   wfin_axis_tdata,
  input  logic                    wfin_axis_tvalid,
  input  logic                    wfin_axis_tlast,
  input  logic [DATA_WIDTH/8-1:0] wfin_axis_tkeep,
  output logic                    wfin_axis_tready,
  output logic [DATA_WIDTH-1:0]   wfout_axis_tdata,
  output logic                    wfout_axis_tvalid,
  output logic                    wfout_axis_tlast,
  output logic [DATA_WIDTH/8-1:0] wfout_axis_tkeep,
  input  logic                    wfout_axis_tready
);

  localparam int              c_DEPTH   = 2 ** ADDR_WIDTH;
  localparam int              c_CW      = ADDR_WIDTH + 1;
  localparam int              c_KW      = DATA_WIDTH / 8;
  localparam logic [31:0]     c_DEPTH32 = 32'(c_DEPTH);
  localparam logic [c_CW-1:0] c_ONE     = c_CW'(1);
  localparam logic            c_WBR     = (WRITE_BEFORE_READ != 0);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_WRITE = 2'd1;
  localparam logic [1:0] c_ST_READY = 2'd2;
  localparam logic [1:0] c_ST_READ  = 2'd3;

  logic [1:0]            r_state;
  logic [1:0]            w_next;

  logic [c_CW-1:0]       r_len;
  logic [c_CW-1:0]       r_slen;
  logic [c_CW-1:0]       r_wcnt;
  logic [c_CW-1:0]       r_rcnt;
  logic [31:0]           r_rep;
  logic [31:0]           r_rep_cnt;
  logic                  r_stop;
  logic                  r_len_err;
  logic                  r_rd_rdy;
  logic [c_KW-1:0]       r_tkeep;

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  r_rd_last;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [DATA_WIDTH-1:0] r_skid_data;
  logic                  r_skid_valid;
  logic                  r_skid_last;

  logic [31:0]           w_par_len;
  logic [31:0]           w_par_rep;
  logic                  w_len_ok;
  logic                  w_idle_rdy;
  logic                  w_wr_start;
  logic                  w_len_reject;
  logic                  w_rd_start;
  logic                  w_wr_hs;
  logic                  w_wr_end;
  logic                  w_pop;
  logic                  w_final_rep;
  logic                  w_done;
  logic [c_CW-1:0]       w_cur_slen;
  logic                  w_rd_last;
  logic [1:0]            w_occ;
  logic                  w_space;
  logic                  w_issue;
  logic                  w_unused;

  // Capture keep strobes and the reserved parameter bits carry no meaning here.
  assign w_unused = ^{wfin_axis_tkeep, waveform_parameters[127:64]};

  assign w_par_len    = waveform_parameters[31:0];
  assign w_par_rep    = waveform_parameters[63:32];
  assign w_len_ok     = (w_par_len != 32'd0) && (w_par_len <= c_DEPTH32);
  assign w_idle_rdy   = (r_state == c_ST_IDLE) || (r_state == c_ST_READY);
  assign w_wr_start   = w_idle_rdy && init_wf_write && w_len_ok;
  assign w_len_reject = w_idle_rdy && init_wf_write && !w_len_ok;
  // A capture request always takes priority over a playback request.
  assign w_rd_start   = w_idle_rdy && !init_wf_write && init_wf_read &&
                        ((r_state == c_ST_READY) || (!c_WBR && w_len_ok));

  assign w_wr_hs  = (r_state == c_ST_WRITE) && wfin_axis_tvalid;
  assign w_wr_end = w_wr_hs && (wfin_axis_tlast || (r_wcnt == r_len - c_ONE));

  // Playback terminates only on an output-side tlast handshake; words already
  // prefetched for the following repetition are flushed at that point.
  assign w_pop       = r_out_valid && wfout_axis_tready;
  assign w_final_rep = r_stop || stop_wf_read ||
                       ((r_rep != 32'd0) && (r_rep_cnt == r_rep - 32'd1));
  assign w_done      = (r_state == c_ST_READ) && w_pop && r_out_last && w_final_rep;

  // Without write-before-read, a start from IDLE replays LEN words as given now.
  assign w_cur_slen = (w_rd_start && (r_state == c_ST_IDLE)) ? w_par_len[c_CW-1:0] : r_slen;
  assign w_rd_last  = (r_rcnt == w_cur_slen - c_ONE);

  // Output register plus skid register give two slots; a read is issued only
  // when the slot it will land in is guaranteed free.
  assign w_occ   = {1'b0, r_out_valid} + {1'b0, r_skid_valid} + {1'b0, r_rd_valid};
  assign w_space = (w_occ - {1'b0, w_pop}) < 2'd2;
  assign w_issue = (((r_state == c_ST_READ) && !w_done) || w_rd_start) && w_space;

  // State register.
  always_ff @(posedge clk_in1 or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_IDLE, c_ST_READY: begin
        if (w_wr_start) begin
          w_next = c_ST_WRITE;
        end else if (w_rd_start) begin
          w_next = c_ST_READ;
        end
      end
      c_ST_WRITE: begin
        if (w_wr_end) begin
          w_next = c_ST_READY;
        end
      end
      c_ST_READ: begin
        if (w_done) begin
          w_next = c_ST_READY;
        end
      end
      default: w_next = c_ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    wf_write_ready   = (r_state == c_ST_WRITE);
    wf_busy          = (r_state == c_ST_WRITE) || (r_state == c_ST_READ);
    wfin_axis_tready = (r_state == c_ST_WRITE);
  end

  assign wf_read_ready     = r_rd_rdy;
  assign wf_len_error      = r_len_err;
  assign wfout_axis_tdata  = r_out_data;
  assign wfout_axis_tvalid = r_out_valid;
  assign wfout_axis_tlast  = r_out_last;
  assign wfout_axis_tkeep  = r_tkeep;

  // Length, counters, repetition bookkeeping and registered status flags.
  always_ff @(posedge clk_in1 or negedge aresetn) begin
    if (!aresetn) begin
      r_len     <= '0;
      r_slen    <= '0;
      r_wcnt    <= '0;
      r_rcnt    <= '0;
      r_rep     <= '0;
      r_rep_cnt <= '0;
      r_stop    <= 1'b0;
      r_len_err <= 1'b0;
      r_rd_rdy  <= 1'b0;
      r_tkeep   <= '0;
    end else begin
      r_len_err <= w_len_reject;
      r_rd_rdy  <= (w_next == c_ST_READY) || (!c_WBR && (w_next == c_ST_IDLE));
      r_tkeep   <= '1;

      if (w_wr_start) begin
        r_len  <= w_par_len[c_CW-1:0];
        r_wcnt <= '0;
      end else if (w_wr_hs) begin
        r_wcnt <= r_wcnt + c_ONE;
      end

      if (w_wr_end) begin
        r_slen <= r_wcnt + c_ONE;
      end else if (w_rd_start && (r_state == c_ST_IDLE)) begin
        r_slen <= w_par_len[c_CW-1:0];
      end

      if (w_rd_start) begin
        r_rep     <= w_par_rep;
        r_rep_cnt <= '0;
        r_stop    <= 1'b0;
      end else if (r_state == c_ST_READ) begin
        if (stop_wf_read) begin
          r_stop <= 1'b1;
        end
        if (w_pop && r_out_last) begin
          r_rep_cnt <= r_rep_cnt + 32'd1;
        end
      end

      if (w_issue) begin
        r_rcnt <= w_rd_last ? '0 : r_rcnt + c_ONE;
      end else if (w_done || (r_state != c_ST_READ)) begin
        r_rcnt <= '0;
      end
    end
  end

  // Block RAM: capture write port and registered playback read port.
  always_ff @(posedge clk_in1) begin
    if (w_wr_hs) begin
      r_mem[r_wcnt[ADDR_WIDTH-1:0]] <= wfin_axis_tdata;
    end
    if (w_issue) begin
      r_rd_data <= r_mem[r_rcnt[ADDR_WIDTH-1:0]];
    end
  end

  // Read-return tracking plus output/skid registers of the playback stream.
  always_ff @(posedge clk_in1 or negedge aresetn) begin
    if (!aresetn) begin
      r_rd_valid   <= 1'b0;
      r_rd_last    <= 1'b0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_skid_data  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_last  <= 1'b0;
    end else begin
      r_rd_valid <= w_issue;
      if (w_issue) begin
        r_rd_last <= w_rd_last;
      end

      if (w_done || (r_state != c_ST_READ)) begin
        r_out_valid  <= 1'b0;
        r_out_last   <= 1'b0;
        r_skid_valid <= 1'b0;
      end else if (!r_out_valid || w_pop) begin
        if (r_skid_valid) begin
          r_out_data   <= r_skid_data;
          r_out_last   <= r_skid_last;
          r_out_valid  <= 1'b1;
          r_skid_valid <= r_rd_valid;
          r_skid_data  <= r_rd_data;
          r_skid_last  <= r_rd_last;
        end else begin
          r_out_valid <= r_rd_valid;
          r_out_data  <= r_rd_data;
          r_out_last  <= r_rd_last;
        end
      end else if (r_rd_valid) begin
        r_skid_data  <= r_rd_data;
        r_skid_last  <= r_rd_last;
        r_skid_valid <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_waveform_playback_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_waveform_playback_buffer
// Description : Directed self-checking bench for waveform_playback_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_waveform_playback_buffer;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int KW = DW / 8;

  logic          clk_in1;
  logic          aresetn;
  logic [127:0]  waveform_parameters;
  logic          init_wf_write;
  logic          init_wf_read;
  logic          stop_wf_read;
  logic          wf_write_ready;
  logic          wf_read_ready;
  logic          wf_busy;
  logic          wf_len_error;
  logic [DW-1:0] wfin_axis_tdata;
  logic          wfin_axis_tvalid;
  logic          wfin_axis_tlast;
  logic [KW-1:0] wfin_axis_tkeep;
  logic          wfin_axis_tready;
  logic [DW-1:0] wfout_axis_tdata;
  logic          wfout_axis_tvalid;
  logic          wfout_axis_tlast;
  logic [KW-1:0] wfout_axis_tkeep;
  logic          wfout_axis_tready;

  waveform_playback_buffer #(
    .DATA_WIDTH        (DW),
    .ADDR_WIDTH        (AW),
    .WRITE_BEFORE_READ (1)
  ) dut (
    .clk_in1             (clk_in1),
    .aresetn             (aresetn),
    .waveform_parameters (waveform_parameters),
    .init_wf_write       (init_wf_write),
    .init_wf_read        (init_wf_read),
    .stop_wf_read        (stop_wf_read),
    .wf_write_ready      (wf_write_ready),
    .wf_read_ready       (wf_read_ready),
    .wf_busy             (wf_busy),
    .wf_len_error        (wf_len_error),
    .wfin_axis_tdata     (wfin_axis_tdata),
    .wfin_axis_tvalid    (wfin_axis_tvalid),
    .wfin_axis_tlast     (wfin_axis_tlast),
    .wfin_axis_tkeep     (wfin_axis_tkeep),
    .wfin_axis_tready    (wfin_axis_tready),
    .wfout_axis_tdata    (wfout_axis_tdata),
    .wfout_axis_tvalid   (wfout_axis_tvalid),
    .wfout_axis_tlast    (wfout_axis_tlast),
    .wfout_axis_tkeep    (wfout_axis_tkeep),
    .wfout_axis_tready   (wfout_axis_tready)
  );

  initial clk_in1 = 1'b0;
  always #5 clk_in1 = ~clk_in1;

  int n_cmp = 0;
  int n_err = 0;

  int            cyc         = 0;
  int            last_hs_cyc = -1;
  logic [DW-1:0] q_data[$];
  logic          q_last[$];
  int            stall_viol  = 0;
  logic          prev_stall  = 1'b0;
  logic [DW-1:0] held_data   = '0;
  logic          held_last   = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output-stream monitor: records handshakes and flags data changing under stall.
  always @(posedge clk_in1) begin
    cyc++;
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!wfout_axis_tvalid || wfout_axis_tdata !== held_data ||
                         wfout_axis_tlast !== held_last))
        stall_viol++;
      if (wfout_axis_tvalid && wfout_axis_tready) begin
        q_data.push_back(wfout_axis_tdata);
        q_last.push_back(wfout_axis_tlast);
        last_hs_cyc = cyc;
      end
      prev_stall = wfout_axis_tvalid && !wfout_axis_tready;
      held_data  = wfout_axis_tdata;
      held_last  = wfout_axis_tlast;
    end
  end

  task automatic tick();
    @(posedge clk_in1);
    #1;
  endtask

  task automatic capture(input int len, input int nbeats, input int last_idx,
                         input logic [DW-1:0] base, input bit with_read);
    waveform_parameters[31:0] = 32'(len);
    init_wf_write = 1'b1;
    init_wf_read  = with_read;
    tick();
    init_wf_write = 1'b0;
    init_wf_read  = 1'b0;
    check_eq("cap_wr_ready", wf_write_ready, 1);
    check_eq("cap_busy", wf_busy, 1);
    for (int i = 0; i < nbeats; i++) begin
      wfin_axis_tdata  = base + DW'(i);
      wfin_axis_tvalid = 1'b1;
      wfin_axis_tlast  = (i == last_idx);
      tick();
    end
    wfin_axis_tvalid = 1'b0;
    wfin_axis_tlast  = 1'b0;
    check_eq("cap_tready_off", wfin_axis_tready, 0);
    check_eq("cap_read_ready", wf_read_ready, 1);
  endtask

  task automatic playback(input logic [31:0] rep, input bit rnd, input int stop_at,
                          input int max_cyc, output int tmo, output int lat);
    int  start_cyc;
    int  first;
    bit  stop_sent;
    first     = -1;
    stop_sent = 1'b0;
    q_data.delete();
    q_last.delete();
    waveform_parameters[63:32] = rep;
    wfout_axis_tready = 1'b1;
    init_wf_read      = 1'b1;
    start_cyc         = cyc;
    tmo               = 1;
    for (int k = 0; k < max_cyc; k++) begin
      tick();
      init_wf_read = 1'b0;
      stop_wf_read = 1'b0;
      if (wfout_axis_tvalid && first < 0) first = cyc - start_cyc;
      if (wf_read_ready) begin
        tmo = 0;
        break;
      end
      wfout_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stop_at >= 0 && !stop_sent && q_data.size() >= stop_at) begin
        stop_wf_read = 1'b1;
        stop_sent    = 1'b1;
      end
    end
    stop_wf_read      = 1'b0;
    wfout_axis_tready = 1'b1;
    lat               = first;
  endtask

  task automatic check_stream(input string tag, input int slen, input int nrep, input logic [DW-1:0] base);
    int n;
    check_eq({tag, "_count"}, 64'(q_data.size()), 64'(slen * nrep));
    n = (q_data.size() < slen * nrep) ? q_data.size() : slen * nrep;
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_data[%0d]", tag, i), 64'(q_data[i]), 64'(base + DW'(i % slen)));
      check_eq($sformatf("%s_last[%0d]", tag, i), 64'(q_last[i]), 64'((i % slen) == slen - 1));
    end
  endtask

  task automatic check_end(input string tag);
    check_eq({tag, "_end_tvalid"}, wfout_axis_tvalid, 0);
    check_eq({tag, "_end_cycle"}, 64'(cyc - last_hs_cyc), 0);
    check_eq({tag, "_end_busy"}, wf_busy, 0);
  endtask

  initial begin
    int  tmo;
    int  lat;
    bit  seen;

    aresetn             = 1'b0;
    waveform_parameters = '0;
    init_wf_write       = 1'b0;
    init_wf_read        = 1'b0;
    stop_wf_read        = 1'b0;
    wfin_axis_tdata     = '0;
    wfin_axis_tvalid    = 1'b0;
    wfin_axis_tlast     = 1'b0;
    wfin_axis_tkeep     = '1;
    wfout_axis_tready   = 1'b1;

    // Reset state.
    tick();
    tick();
    check_eq("rst_status", {wf_write_ready, wf_read_ready, wf_busy, wf_len_error,
                            wfin_axis_tready, wfout_axis_tvalid, wfout_axis_tlast}, 0);
    check_eq("rst_tkeep", wfout_axis_tkeep, 0);
    check_eq("rst_tdata", wfout_axis_tdata, 0);
    aresetn = 1'b1;
    #1;
    check_eq("post_rst_status", {wf_write_ready, wf_read_ready, wf_busy, wf_len_error,
                                 wfin_axis_tready, wfout_axis_tvalid}, 0);
    tick();
    check_eq("tkeep_ones", wfout_axis_tkeep, 4'hF);

    // Playback without a stored waveform is ignored.
    waveform_parameters = {64'd0, 32'd1, 32'd16};
    init_wf_read = 1'b1;
    tick();
    init_wf_read = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      tick();
      seen |= wfout_axis_tvalid | wf_busy | wf_read_ready;
    end
    check_eq("wbr_read_ignored", seen, 0);

    // LEN = 0 rejected in IDLE.
    waveform_parameters[31:0] = 32'd0;
    init_wf_write = 1'b1;
    tick();
    init_wf_write = 1'b0;
    check_eq("len0_err", wf_len_error, 1);
    check_eq("len0_wr_ready", wf_write_ready, 0);
    tick();
    check_eq("len0_err_pulse", wf_len_error, 0);
    check_eq("len0_state", {wf_busy, wf_read_ready}, 0);

    // LEN=128 ramp, single repetition, free-flowing output.
    capture(128, 128, -1, 32'd0, 1'b0);
    playback(32'd1, 1'b0, -1, 400, tmo, lat);
    check_eq("ramp_timeout", tmo, 0);
    check_eq("ramp_latency", 64'(lat), 2);
    check_end("ramp");
    check_stream("ramp", 128, 1, 32'd0);

    // LEN = DEPTH+1 rejected in READY, state kept.
    waveform_parameters[31:0] = 32'd1025;
    init_wf_write = 1'b1;
    tick();
    init_wf_write = 1'b0;
    check_eq("lenbig_err", wf_len_error, 1);
    check_eq("lenbig_wr_ready", wf_write_ready, 0);
    check_eq("lenbig_read_ready", wf_read_ready, 1);
    tick();
    check_eq("lenbig_err_pulse", wf_len_error, 0);

    // LEN=8, three repetitions under random backpressure.
    capture(8, 8, -1, 32'hC0DE_0000, 1'b0);
    stall_viol = 0;
    playback(32'd3, 1'b1, -1, 600, tmo, lat);
    check_eq("rep3_timeout", tmo, 0);
    check_eq("rep3_latency", 64'(lat), 2);
    check_end("rep3");
    check_stream("rep3", 8, 3, 32'hC0DE_0000);
    check_eq("rep3_stall_hold", 64'(stall_viol), 0);

    // LEN=16 continuous, stop requested after 20 beats.
    capture(16, 16, -1, 32'h5500_0000, 1'b0);
    playback(32'd0, 1'b0, 20, 400, tmo, lat);
    check_eq("stop_timeout", tmo, 0);
    check_end("stop");
    check_stream("stop", 16, 2, 32'h5500_0000);

    // LEN=64 capture cut short by tlast on the tenth beat.
    capture(64, 10, 9, 32'hABC0_0000, 1'b0);
    playback(32'd1, 1'b0, -1, 200, tmo, lat);
    check_eq("short_timeout", tmo, 0);
    check_end("short");
    check_stream("short", 10, 1, 32'hABC0_0000);

    // Simultaneous capture and playback request in READY: capture wins.
    q_data.delete();
    q_last.delete();
    capture(8, 8, -1, 32'h7700_0000, 1'b1);
    check_eq("tie_no_output", 64'(q_data.size()), 0);

    // Reset in the middle of continuous playback.
    waveform_parameters[63:32] = 32'd0;
    init_wf_read = 1'b1;
    tick();
    init_wf_read = 1'b0;
    tmo = 1;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (q_data.size() >= 5) begin
        tmo = 0;
        break;
      end
    end
    check_eq("rst_mid_reach", tmo, 0);
    check_eq("rst_mid_data", 64'(q_data.size() > 0 ? q_data[0] : 32'hDEAD_BEEF), 64'h7700_0000);
    aresetn = 1'b0;
    #1;
    check_eq("rst_mid_tvalid", wfout_axis_tvalid, 0);
    check_eq("rst_mid_busy", wf_busy, 0);
    tick();
    tick();
    aresetn = 1'b1;
    tick();
    check_eq("rst_mid_read_ready", wf_read_ready, 0);
    waveform_parameters[31:0] = 32'd8;
    init_wf_read = 1'b1;
    tick();
    init_wf_read = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      tick();
      seen |= wfout_axis_tvalid | wf_busy | wf_read_ready;
    end
    check_eq("rst_mid_invalidated", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/waveform_playback_buffer.md
# waveform_playback_buffer

Parametrised successor to the single-shot waveform stream buffer in the FMC transmit path. It captures one waveform from an AXI4-Stream input into on-chip block RAM and replays it on an AXI4-Stream output. Replay runs either a programmed number of times or continuously until stopped. Width and depth are generic. The block adds repeat/loop playback, graceful stop and length checking.

## Interface
Parameters:
- DATA_WIDTH, 32, sample word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10, RAM address width; depth DEPTH = 2^ADDR_WIDTH words.
- WRITE_BEFORE_READ, 1, if 1, playback requires a completely stored waveform.

Ports:
- clk_in1  in  1  sole clock; all logic is rising-edge.
- aresetn  in  1  asynchronous, active-low reset.
- waveform_parameters  in  128  [31:0] length in words (LEN); [63:32] repeat count (REP, 0 = continuous); [127:64] reserved, ignored.
- init_wf_write  in  1  level request to start capture; sampled in IDLE/READY.
- init_wf_read  in  1  level request to start playback; sampled in IDLE/READY.
- stop_wf_read  in  1  request to end continuous or repeated playback.
- wf_write_ready  out  1  high while in WRITE; acknowledges init_wf_write.
- wf_read_ready  out  1  playback may be started.
- wf_busy  out  1  high in WRITE or READ.
- wf_len_error  out  1  one-cycle pulse when a capture request is rejected for LEN.
- wfin_axis_tdata/tvalid/tlast/tkeep/tready  in,in,in,in,out  DATA_WIDTH,1,1,DATA_WIDTH/8,1  capture stream.
- wfout_axis_tdata/tvalid/tlast/tkeep/tready  out,out,out,out,in  DATA_WIDTH,1,1,DATA_WIDTH/8,1  playback stream.

## Operation
- The FSM has four states: IDLE, WRITE, READY, READ. Reset enters IDLE.
- The stored-length register is cleared on reset. Memory contents are not reset.
- Capture request in IDLE/READY with init_wf_write=1:
  - LEN is latched.
  - If LEN==0 or LEN>DEPTH: pulse wf_len_error and stay in the current state.
  - Otherwise go to WRITE.
- WRITE:
  - wfin_axis_tready=1.
  - Each handshake writes tdata to address wcnt, then wcnt increments. tkeep is ignored.
  - Capture ends on the handshake where wcnt==LEN-1, or on an earlier tlast.
  - Stored length SLEN = number of beats accepted. Go to READY.
- READY: wf_read_ready=1.
- With WRITE_BEFORE_READ=0, wf_read_ready=1 in IDLE too; playback then uses SLEN=LEN as latched now.
- init_wf_write and init_wf_read high together in IDLE/READY: write wins.
- Playback request with init_wf_read=1: latch REP and go to READ.
- READ:
  - Output words at addresses 0..SLEN-1 in order, once per repetition.
  - tlast is asserted on word SLEN-1 of every repetition.
  - tkeep is all ones.
  - Repetitions run until REP are done (REP>0), or indefinitely (REP=0).
- stop_wf_read is sampled any cycle in READ and sets a sticky stop flag. Playback ends after the tlast handshake of the current repetition, then go to READY.
- init_wf_write and init_wf_read are ignored in WRITE and READ. stop_wf_read is ignored outside READ.
- Counter widths: wcnt/rcnt are ADDR_WIDTH+1 bits; repetition counter is 32 bits. No wrap-around inside a repetition.

## Timing
- All outputs are 0 during reset and in the cycle after reset release, except tkeep, which is 0 during reset.
- wf_write_ready is high the cycle after init_wf_write is sampled. The requester must drop init_wf_write once it sees wf_write_ready.
- Last capture handshake at cycle N: tready=0 at N+1, wf_read_ready=1 at N+1.
- init_wf_read sampled at cycle 0: first wfout_axis_tvalid at cycle 2. This covers the registered RAM read plus the output register.
- Throughput is 1 beat per cycle while tready=1. A one-entry skid register hides the RAM latency under backpressure.
- tdata, tlast and tvalid are held stable while tvalid=1 and tready=0.
- There are no gaps between repetitions.
- Final handshake at cycle M: tvalid=0 at M+1, wf_read_ready=1 at M+1.
- Reset assertion mid-WRITE/READ drops all outputs immediately and returns to IDLE. The stored waveform is invalidated.

## Test plan
- LEN=128, REP=1, ramp 0..127 captured, tready always 1: out = 0..127 contiguous, tlast on word 127 only, first tvalid 2 cycles after init_wf_read.
- LEN=8, REP=3, random tready backpressure: 24 beats with data 0..7 three times, tlast on beats 7/15/23, no data change while stalled.
- LEN=16, REP=0, stop_wf_read pulsed at beat 20: playback ends on beat 31 (tlast), wf_read_ready=1 next cycle.
- LEN=0 and LEN=DEPTH+1: wf_len_error one-cycle pulse each, wf_write_ready stays 0, state unchanged. LEN=64 with tlast on beat 10: SLEN=10, replay yields 10 words.
- WRITE_BEFORE_READ=1, init_wf_read after reset with no capture: ignored, tvalid stays 0. Simultaneous init_wf_write/init_wf_read in READY: WRITE entered.
- aresetn asserted mid-READ at beat 5: tvalid=0 immediately. After release, wf_read_ready=0 until a new capture completes.
